// File: rtl/pov_rx_pkg.sv
// Shared constants, FSM state type and baud helper for the POV string receiver.
package pov_rx_pkg;

  localparam int          STR_W     = 77;
  localparam int          CHAR_W    = 7;
  localparam int          MAX_CHARS = 11;
  localparam logic [7:0]  TERM      = 8'h0D;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  // Clock cycles per UART bit; integer division, rounding down.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, bit timer and receive FSM.
// Emits a one-cycle byte_valid with the byte, or a one-cycle frame_err.
module uart_rx_byte
  import pov_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]       sync_q;
  logic             rx_s;
  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  assign rx_s = sync_q[1];

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], rx};
  end

  // FSM, bit timer, shift register and output pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic: start bit qualified at mid-bit, data/stop sampled a
  // full bit period apart so every sample lands mid-bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_END) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;  // high at mid-start is a glitch
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};  // LSB first
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_END) begin
          cnt_d = '0;
          if (rx_s) begin
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_IDLE: begin
        // A held-low line must return high before a new start is trusted.
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_valid = valid_q;
  assign byte_data  = shift_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_string_receiver.sv
// Packs UART text into a fixed string of 7-bit characters and publishes it
// with a level ready on CR or when the string is full.
module uart_string_receiver #(
  parameter int         CLK_HZ    = 50000000,
  parameter int         BAUD      = 9600,
  parameter int         MAX_CHARS = pov_rx_pkg::MAX_CHARS,
  parameter int         CHAR_W    = pov_rx_pkg::CHAR_W,
  parameter logic [7:0] TERM      = pov_rx_pkg::TERM
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            rx,
  output logic [0:MAX_CHARS*CHAR_W-1]     String,
  output logic                            ready,
  output logic [3:0]                      char_count,
  output logic                            frame_err
);

  localparam int W = MAX_CHARS * CHAR_W;

  logic             byte_valid;
  logic [7:0]       byte_data;
  logic [0:W-1]     asm_q, asm_d, asm_w;
  logic [0:W-1]     str_q, str_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             rdy_q, rdy_d;
  logic             publish;

  uart_rx_byte #(
    .CLKS_PER_BIT(pov_rx_pkg::clks_per_bit(CLK_HZ, BAUD))
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  // Packer registers: assembly, count, published string and ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      asm_q <= '0;
      str_q <= '0;
      cnt_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      asm_q <= asm_d;
      str_q <= str_d;
      cnt_q <= cnt_d;
      rdy_q <= rdy_d;
    end
  end

  // Accept, discard or terminate on each received byte; publishing copies
  // the assembly (including a char written this cycle) and clears it.
  always_comb begin
    asm_w   = asm_q;
    cnt_d   = cnt_q;
    rdy_d   = rdy_q;
    str_d   = str_q;
    publish = 1'b0;
    if (byte_valid) begin
      if (byte_data == TERM) begin
        publish = (cnt_q != 4'd0);
      end else if (byte_data == 8'h00 || byte_data[7] || byte_data == 8'h0A) begin
        publish = 1'b0;  // control/non-ASCII bytes are dropped silently
      end else begin
        asm_w[int'(cnt_q)*CHAR_W +: CHAR_W] = byte_data[CHAR_W-1:0];
        cnt_d = cnt_q + 4'd1;
        rdy_d = 1'b0;  // first char of a new message retracts the old one
        publish = (int'(cnt_q) + 1 == MAX_CHARS);
      end
    end
    asm_d = asm_w;
    if (publish) begin
      str_d = asm_w;
      rdy_d = 1'b1;
      asm_d = '0;
      cnt_d = 4'd0;
    end
  end

  assign String     = str_q;
  assign ready      = rdy_q;
  assign char_count = cnt_q;

endmodule

// File: tb/tb_uart_string_receiver.sv
// Directed + random bench for uart_string_receiver at 16 clocks per bit.
module tb_uart_string_receiver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic [0:76] str_o;
  logic        ready;
  logic [3:0]  char_count;
  logic        frame_err;

  int tests = 0;
  int fails = 0;
  int fe_cycles = 0;

  // Behavioural model of the published state.
  logic [6:0]  m_chars[$];
  logic [0:76] m_str = '0;
  logic        m_rdy = 1'b0;

  uart_string_receiver #(
    .CLK_HZ(160), .BAUD(10), .MAX_CHARS(11), .CHAR_W(7), .TERM(8'h0D)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx), .String(str_o),
    .ready(ready), .char_count(char_count), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_err) fe_cycles <= fe_cycles + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [76:0] obs, input logic [76:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_publish();
    m_str = '0;
    for (int k = 0; k < m_chars.size(); k++)
      for (int j = 0; j < 7; j++)
        m_str[7*k + j] = m_chars[k][6-j];
    m_rdy = 1'b1;
    m_chars.delete();
  endtask

  task automatic m_byte(input logic [7:0] b);
    if (b == 8'h0D) begin
      if (m_chars.size() > 0) m_publish();
    end else if (b == 8'h00 || b >= 8'h80 || b == 8'h0A) begin
      // dropped
    end else begin
      m_chars.push_back(b[6:0]);
      m_rdy = 1'b0;
      if (m_chars.size() == 11) m_publish();
    end
  endtask

  task automatic m_reset();
    m_chars.delete();
    m_str = '0;
    m_rdy = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0; tick(16);
    for (int i = 0; i < 8; i++) begin rx = b[i]; tick(16); end
    rx = stop_bit; tick(16);
  endtask

  task automatic check_all(input string tag);
    chk({tag, " String"}, str_o, m_str);
    chk({tag, " ready"}, 77'(ready), 77'(m_rdy));
    chk({tag, " count"}, 77'(char_count), 77'(m_chars.size()));
  endtask

  task automatic send_char(input logic [7:0] b, input string tag);
    send_frame(b, 1'b1);
    rx = 1'b1;
    tick(8);
    m_byte(b);
    check_all(tag);
  endtask

  initial begin
    logic [0:76] snap;
    logic [0:76] hola_exp;
    int fe0;
    logic [7:0] rb;
    int cat;

    // Reset state
    tick(4);
    chk("rst String", str_o, 77'd0);
    chk("rst ready", 77'(ready), 77'd0);
    chk("rst count", 77'(char_count), 77'd0);
    chk("rst ferr", 77'(frame_err), 77'd0);
    reset = 1'b0;
    tick(20);

    // 1: "HOLA\r"
    send_char("H", "hola H");
    send_char("O", "hola O");
    send_char("L", "hola L");
    send_char("A", "hola A");
    send_char(8'h0D, "hola CR");
    hola_exp = {7'b1001000, 7'b1001111, 7'b1001100, 7'b1000001, 49'd0};
    chk("hola const", str_o, hola_exp);
    chk("hola ready", 77'(ready), 77'd1);

    // 2: eleven chars, no terminator, then 'X'
    for (int i = 0; i < 11; i++) send_char(8'h41 + 8'(i), "fill");
    snap = str_o;
    chk("fill K slot", 77'(snap[70:76]), 77'(7'b1001011));
    chk("fill ready", 77'(ready), 77'd1);
    send_char("X", "after X");
    chk("X keeps String", str_o, snap);
    chk("X count", 77'(char_count), 77'd1);

    // 3: bad stop bit, line held low, then recovery
    fe0 = fe_cycles;
    send_frame(8'h41, 1'b0);
    rx = 1'b0;
    tick(40);
    chk("ferr pulse", 77'(fe_cycles - fe0), 77'd1);
    check_all("ferr state");
    rx = 1'b1;
    tick(20);
    send_char("B", "after ferr B");
    chk("ferr no extra", 77'(fe_cycles - fe0), 77'd1);

    // 4: short low glitch
    rx = 1'b0; tick(6); rx = 1'b1; tick(40);
    check_all("glitch");

    // 5: reset in the middle of 'Z' data bit 4
    send_char("H", "pre H");
    send_char("I", "pre I");
    rx = 1'b0; tick(16);
    for (int i = 0; i < 4; i++) begin rx = 8'h5A >> i; tick(16); end
    rx = 1'b0; tick(8);
    reset = 1'b1; rx = 1'b1; tick(3);
    chk("mid rst String", str_o, 77'd0);
    chk("mid rst ready", 77'(ready), 77'd0);
    chk("mid rst count", 77'(char_count), 77'd0);
    chk("mid rst ferr", 77'(frame_err), 77'd0);
    reset = 1'b0;
    m_reset();
    tick(20);
    send_char("Q", "Q");
    send_char(8'h0D, "Q CR");
    chk("Q const", str_o, {7'b1010001, 70'd0});

    // 6: ignored bytes
    snap = str_o;
    send_char(8'h0D, "empty CR");
    send_char(8'hC1, "hi byte");
    send_char(8'h00, "nul");
    send_char(8'h0A, "lf");
    chk("ignored String", str_o, snap);
    chk("ignored ready", 77'(ready), 77'd1);

    // Random mix of printable, terminators and dropped bytes
    for (int n = 0; n < 40; n++) begin
      cat = $urandom_range(0, 9);
      case (cat)
        0:       rb = 8'h0D;
        1:       rb = 8'h0A;
        2:       rb = 8'h00;
        3:       rb = 8'h80 | 8'($urandom_range(0, 127));
        default: rb = 8'h20 + 8'($urandom_range(0, 94));
      endcase
      send_char(rb, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
